map_ss_engine: RTL and testbench
================================

// Module: map_ss_engine
// PURPOSE
// Save-state sequencer for mapper cores: walks ss_addr across the mapper register window.
// SAVE reads each byte from the mapper's ss_rdat and streams it to the host.
// LOAD writes host bytes back into the mapper, holding each write across an M2 falling edge, since mapper registers clock on negedge m2.
// Sits between the host/menu DMA stream and the ss_ctrl bus of the active mapper.
// PARAMETERS
// SS_LEN      128   bytes per state image; ss_addr runs 0..SS_LEN-1 (byte SS_LEN-1 = map_idx)
// M2_SYNC     2     synchronizer flops on m2 (min 2)
// M2_TMO      4095  clk cycles to wait for an M2 fall before fault
// PORTS
// clk        in   1   system clock
// rst_n      in   1   async active-low reset
// m2         in   1   CPU M2, asynchronous to clk
// cmd_save   in   1   1-clk pulse: start SAVE (ignored unless IDLE)
// cmd_load   in   1   1-clk pulse: start LOAD (ignored unless IDLE; save wins if both)
// abort      in   1   return to IDLE next clk, drop ss_act
// busy       out  1   high in any state but IDLE
// done       out  1   1-clk pulse on normal completion
// fault      out  1   sticky; set on M2 timeout, cleared by next cmd_*
// ss_act     out  1   save-state bus ownership to mapper
// ss_addr    out  8   mapper save-state register index
// ss_we      out  1   mapper write enable (held through M2 fall)
// ss_wdat    out  8   write data (muxed onto mapper cpu_dat while ss_act)
// ss_rdat    in   8   mapper read data, combinational from ss_addr
// rd_dat     out  8   SAVE stream data
// rd_valid   out  1   SAVE stream valid
// rd_ready   in   1   SAVE stream ready
// wr_dat     in   8   LOAD stream data
// wr_valid   in   1   LOAD stream valid
// wr_ready   out  1   LOAD stream ready
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; ss_addr 0; fault 0.
// - m2 passes M2_SYNC flops; m2_fall = prev synced 1 & current synced 0.
// - States: IDLE, S_SET, S_CAP, S_PUSH, L_GET, L_ARM, L_HOLD, FIN.
// - IDLE -cmd_save-> S_SET, ss_act=1, ss_addr=0. IDLE -cmd_load-> L_GET, ss_act=1, ss_addr=0.
// - S_SET: one settle clk for ss_rdat -> S_CAP.
// - S_CAP: latch ss_rdat into rd_dat -> S_PUSH.
// - S_PUSH: rd_valid=1, rd_dat stable until rd_valid&rd_ready.
//   On handshake: last addr -> FIN; else addr+1, -> S_SET.
//   Per-byte latency with ready held high: 3 clk.
// - L_GET: wr_ready=1. On wr_valid&wr_ready, latch wr_dat into ss_wdat -> L_ARM.
// - L_ARM: ss_we=1; wait for m2_fall -> L_HOLD. Timer counts clk in L_ARM.
//   At M2_TMO: fault=1, ss_we=0 -> FIN with no done.
// - L_HOLD: ss_we and ss_wdat held 2 more clk past the detected fall (covers sync skew), then ss_we=0.
//   Last addr -> FIN; else addr+1, -> L_GET.
// - ss_addr/ss_wdat change only while ss_we=0; never change during L_ARM/L_HOLD.
// - FIN: ss_act=0, done=1 for one clk (not on fault) -> IDLE.
// - abort in any state: next clk IDLE; ss_act, ss_we, rd_valid, wr_ready = 0; no done. abort beats cmd_* in the same clk.
// - cmd_* while busy: ignored, no effect on state or fault.
// - ss_addr is 8 bits; SS_LEN must be <= 256; last addr = SS_LEN-1, no wrap.
// - rst_n low mid-operation: immediate IDLE state; partial load is not rolled back.
// TESTING
// - SAVE with model returning ss_rdat = addr^8'h5A and rd_ready=1 -> 128 bytes 5A,5B..25 in order; done once; 3 clk/byte.
// - SAVE with rd_ready toggling every 3 clk -> rd_dat stable while valid & !ready; no byte lost or duplicated.
// - LOAD 128 bytes (i) with m2 at clk/12 -> model captures on negedge m2 at each addr i:
//   ss_we high at each fall, ss_wdat == i, then done.
// - LOAD with m2 held high -> fault=1 after 4095 clk in L_ARM; ss_act=0; no done; next cmd_save clears fault.
// - abort at addr 40 during LOAD, then cmd_save -> all outputs 0 next clk; SAVE restarts at addr 0.
// - cmd_save & cmd_load same clk, then cmd_load while busy -> SAVE runs, second cmd ignored; rst_n low mid-SAVE -> outputs 0 async.

Source files
------------

// File: rtl/map_ss_engine.sv
// Save-state sequencer: streams the mapper register window out (SAVE)
// or writes host bytes back into it across M2 falling edges (LOAD).
module map_ss_engine #(
    parameter int SS_LEN  = 128,
    parameter int M2_SYNC = 2,
    parameter int M2_TMO  = 4095
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       m2,
    input  logic       cmd_save,
    input  logic       cmd_load,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic       ss_act,
    output logic [7:0] ss_addr,
    output logic       ss_we,
    output logic [7:0] ss_wdat,
    input  logic [7:0] ss_rdat,
    output logic [7:0] rd_dat,
    output logic       rd_valid,
    input  logic       rd_ready,
    input  logic [7:0] wr_dat,
    input  logic       wr_valid,
    output logic       wr_ready
);

    localparam logic [7:0] LAST = 8'(SS_LEN - 1);
    localparam int TW = $clog2(M2_TMO + 1);

    typedef enum logic [2:0] {
        IDLE, S_SET, S_CAP, S_PUSH, L_GET, L_ARM, L_HOLD, FIN
    } state_t;

    state_t              state_q;
    logic [M2_SYNC-1:0]  m2_sync_q;
    logic                m2_prev_q;
    logic [TW-1:0]       tmr_q;
    logic                busy_q, done_q, fault_q, ss_act_q, ss_we_q;
    logic                rd_valid_q, wr_ready_q;
    logic [7:0]          ss_addr_q, ss_wdat_q, rd_dat_q;
    logic                m2_fall;
    logic                is_last;

    assign m2_fall = m2_prev_q & ~m2_sync_q[M2_SYNC-1];
    assign is_last = (ss_addr_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m2_sync_q <= '0;
            m2_prev_q <= 1'b0;
        end else begin
            m2_sync_q <= {m2_sync_q[M2_SYNC-2:0], m2};
            m2_prev_q <= m2_sync_q[M2_SYNC-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tmr_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
            ss_act_q   <= 1'b0;
            ss_we_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            wr_ready_q <= 1'b0;
            ss_addr_q  <= '0;
            ss_wdat_q  <= '0;
            rd_dat_q   <= '0;
        end else if (abort) begin
            state_q    <= IDLE;
            tmr_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ss_act_q   <= 1'b0;
            ss_we_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            wr_ready_q <= 1'b0;
            ss_addr_q  <= '0;
            ss_wdat_q  <= '0;
            rd_dat_q   <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cmd_save || cmd_load) begin
                        busy_q    <= 1'b1;
                        ss_act_q  <= 1'b1;
                        ss_addr_q <= '0;
                        fault_q   <= 1'b0;
                        if (cmd_save) begin
                            state_q <= S_SET;
                        end else begin
                            state_q    <= L_GET;
                            wr_ready_q <= 1'b1;
                        end
                    end
                end
                S_SET: state_q <= S_CAP;
                S_CAP: begin
                    rd_dat_q   <= ss_rdat;
                    rd_valid_q <= 1'b1;
                    state_q    <= S_PUSH;
                end
                S_PUSH: begin
                    if (rd_ready) begin
                        rd_valid_q <= 1'b0;
                        if (is_last) begin
                            ss_act_q <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= FIN;
                        end else begin
                            ss_addr_q <= ss_addr_q + 8'd1;
                            state_q   <= S_SET;
                        end
                    end
                end
                L_GET: begin
                    if (wr_valid) begin
                        ss_wdat_q  <= wr_dat;
                        wr_ready_q <= 1'b0;
                        ss_we_q    <= 1'b1;
                        tmr_q      <= '0;
                        state_q    <= L_ARM;
                    end
                end
                L_ARM: begin
                    // Only accept a fall that happened after ss_we rose;
                    // earlier ones are still draining out of the synchronizer.
                    if (m2_fall && tmr_q > TW'(M2_SYNC)) begin
                        tmr_q   <= '0;
                        state_q <= L_HOLD;
                    end else if (tmr_q == TW'(M2_TMO - 1)) begin
                        fault_q  <= 1'b1;
                        ss_we_q  <= 1'b0;
                        ss_act_q <= 1'b0;
                        state_q  <= FIN;
                    end else begin
                        tmr_q <= tmr_q + TW'(1);
                    end
                end
                L_HOLD: begin
                    if (tmr_q == TW'(1)) begin
                        ss_we_q <= 1'b0;
                        if (is_last) begin
                            ss_act_q <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= FIN;
                        end else begin
                            ss_addr_q  <= ss_addr_q + 8'd1;
                            wr_ready_q <= 1'b1;
                            state_q    <= L_GET;
                        end
                    end else begin
                        tmr_q <= tmr_q + TW'(1);
                    end
                end
                FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign fault    = fault_q;
    assign ss_act   = ss_act_q;
    assign ss_addr  = ss_addr_q;
    assign ss_we    = ss_we_q;
    assign ss_wdat  = ss_wdat_q;
    assign rd_dat   = rd_dat_q;
    assign rd_valid = rd_valid_q;
    assign wr_ready = wr_ready_q;

endmodule

// File: tb/tb_map_ss_engine.sv
// Scoreboard bench for map_ss_engine: a mapper model, a SAVE-stream
// monitor and a LOAD-capture monitor compare against queued expectations.
module tb_map_ss_engine;

    logic       clk, rst_n, m2;
    logic       cmd_save, cmd_load, abort;
    logic       busy, done, fault, ss_act, ss_we;
    logic [7:0] ss_addr, ss_wdat, ss_rdat, rd_dat, wr_dat;
    logic       rd_valid, rd_ready, wr_valid, wr_ready;

    map_ss_engine dut (
        .clk(clk), .rst_n(rst_n), .m2(m2),
        .cmd_save(cmd_save), .cmd_load(cmd_load), .abort(abort),
        .busy(busy), .done(done), .fault(fault), .ss_act(ss_act),
        .ss_addr(ss_addr), .ss_we(ss_we), .ss_wdat(ss_wdat),
        .ss_rdat(ss_rdat), .rd_dat(rd_dat), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .wr_dat(wr_dat), .wr_valid(wr_valid),
        .wr_ready(wr_ready)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", name, got, exp);
        end
    endtask

    // Mapper model: combinational read data
    assign ss_rdat = ss_addr ^ 8'h5A;

    logic [30:0] outs;
    assign outs = {busy, done, fault, ss_act, ss_we, rd_valid, wr_ready,
                   ss_addr, ss_wdat, rd_dat};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic m2_run = 1'b0;
    initial begin
        m2 = 1'b1;
        #3;
        forever begin
            #60;
            m2 = m2_run ? ~m2 : 1'b1;
        end
    end

    // rd_ready: fixed level or a 3-clk toggle pattern
    logic tog_en  = 1'b0;
    logic rdy_fix = 1'b1;
    logic rdy_tog = 1'b1;
    int   tcnt    = 0;
    assign rd_ready = tog_en ? rdy_tog : rdy_fix;
    always begin
        @(posedge clk);
        #1;
        if (tog_en) begin
            tcnt++;
            if (tcnt == 3) begin
                tcnt = 0;
                rdy_tog = ~rdy_tog;
            end
        end
    end

    // SAVE-stream monitor
    logic [7:0] exp_q[$];
    logic       lat_chk = 1'b0;
    int  cyc = 0, last_hs = 0, done_cnt = 0, we_cyc = 0, wrr_cyc = 0;
    bit  have_last = 0, prev_stall = 0;
    logic [7:0] prev_dat = '0;
    always @(negedge clk) begin
        cyc++;
        if (done) done_cnt++;
        if (ss_we) we_cyc++;
        if (wr_ready) wrr_cyc++;
        if (!busy) have_last = 0;
        if (prev_stall && rd_valid)
            check("rd_hold", rd_dat, prev_dat);
        if (rd_valid && rd_ready) begin
            if (exp_q.size() == 0) check("rd_extra", rd_dat, -1);
            else check("rd_dat", rd_dat, exp_q.pop_front());
            if (lat_chk && have_last) check("lat", cyc - last_hs, 3);
            last_hs = cyc;
            have_last = 1;
        end
        prev_stall = rd_valid && !rd_ready;
        prev_dat = rd_dat;
    end

    // LOAD-capture monitor: mapper registers clock on negedge m2
    logic [7:0] exp_mem[256];
    int         cap_cnt[256];
    always @(negedge m2) begin
        if (ss_act && ss_we) begin
            check("cap", ss_wdat, exp_mem[ss_addr]);
            cap_cnt[ss_addr]++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_cmd(logic s, logic l);
        cmd_save = s;
        cmd_load = l;
        tick();
        cmd_save = 1'b0;
        cmd_load = 1'b0;
    endtask

    task automatic wait_idle(int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check("idle_tmo", busy, 0);
    endtask

    task automatic feed(int n);
        for (int i = 0; i < n; i++) begin
            int nb = 0;
            wr_dat = 8'(i);
            wr_valid = 1'b1;
            while (!wr_ready && nb < 500) begin
                tick();
                nb++;
            end
            if (!wr_ready) begin
                check("wr_tmo", 0, 1);
                break;
            end
            tick();
        end
        wr_valid = 1'b0;
    endtask

    task automatic push_save();
        for (int i = 0; i < 128; i++) exp_q.push_back(8'(i) ^ 8'h5A);
    endtask

    initial begin
        int d0, w0, miss;
        rst_n = 1'b0;
        cmd_save = 1'b0;
        cmd_load = 1'b0;
        abort = 1'b0;
        wr_dat = '0;
        wr_valid = 1'b0;
        for (int i = 0; i < 256; i++) begin
            exp_mem[i] = 8'(i);
            cap_cnt[i] = 0;
        end
        #1;
        check("reset_outs", outs, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // SAVE, ready held high
        push_save();
        lat_chk = 1'b1;
        d0 = done_cnt;
        pulse_cmd(1, 0);
        check("save_act", {busy, ss_act, ss_addr}, 10'h300);
        wait_idle(1000);
        check("save_left", exp_q.size(), 0);
        check("save_done", done_cnt - d0, 1);

        // SAVE, ready toggling every 3 clk
        push_save();
        lat_chk = 1'b0;
        tog_en = 1'b1;
        d0 = done_cnt;
        pulse_cmd(1, 0);
        wait_idle(3000);
        tog_en = 1'b0;
        check("tog_left", exp_q.size(), 0);
        check("tog_done", done_cnt - d0, 1);

        // LOAD 128 bytes with m2 at clk/12
        m2_run = 1'b1;
        d0 = done_cnt;
        pulse_cmd(0, 1);
        check("load_rdy", {busy, ss_act, wr_ready}, 3'b111);
        feed(128);
        wait_idle(500);
        check("load_done", done_cnt - d0, 1);
        miss = 0;
        for (int i = 0; i < 128; i++) if (cap_cnt[i] == 0) miss++;
        check("load_miss", miss, 0);
        check("load_fault", fault, 0);

        // LOAD with m2 stuck high -> timeout fault
        m2_run = 1'b0;
        repeat (15) tick();
        d0 = done_cnt;
        w0 = we_cyc;
        pulse_cmd(0, 1);
        feed(1);
        wait_idle(5000);
        check("tmo_fault", fault, 1);
        check("tmo_act", ss_act, 0);
        check("tmo_done", done_cnt - d0, 0);
        check("tmo_we_cyc", we_cyc - w0, 4095);
        pulse_cmd(1, 0);
        check("fault_clr", {fault, busy}, 2'b01);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_save", outs, 0);

        // abort LOAD at addr 40, then SAVE restarts at 0
        m2_run = 1'b1;
        pulse_cmd(0, 1);
        feed(41);
        check("ab_addr", ss_addr, 40);
        d0 = done_cnt;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_outs", outs, 0);
        push_save();
        lat_chk = 1'b1;
        pulse_cmd(1, 0);
        check("restart", {ss_act, ss_addr}, 9'h100);
        wait_idle(1000);
        check("rs_left", exp_q.size(), 0);
        check("rs_done", done_cnt - d0, 1);

        // save+load same clk, then load while busy
        push_save();
        d0 = done_cnt;
        w0 = wrr_cyc;
        pulse_cmd(1, 1);
        repeat (5) tick();
        pulse_cmd(0, 1);
        wait_idle(1000);
        check("both_left", exp_q.size(), 0);
        check("both_done", done_cnt - d0, 1);
        check("both_wrr", wrr_cyc - w0, 0);

        // async reset mid-SAVE
        push_save();
        pulse_cmd(1, 0);
        repeat (50) tick();
        rst_n = 1'b0;
        #1;
        check("async_rst", outs, 0);
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
